// File: rtl/sha256_core_if.sv
// Block-in / digest-out handshake bundle for sha256_core.
// Ports: blk_* upstream block channel, dig_* / digest downstream channel, busy status.
interface sha256_core_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         mode;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] digest;
    logic         busy;

    modport master (
        output blk_valid, blk_data, blk_first, blk_last, mode, dig_ready,
        input  blk_ready, dig_valid, digest, busy
    );

    modport slave (
        input  blk_valid, blk_data, blk_first, blk_last, mode, dig_ready,
        output blk_ready, dig_valid, digest, busy
    );
endinterface

// File: rtl/sha256_core.sv
// Iterative SHA-256/SHA-224 compression engine with chained multi-block state.
// Ports: clk, rst (async, active-high), bus (sha256_core_if.slave: block in, digest out).
package sha256_pkg;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sum0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] sum1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
endpackage

module sha256_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    sha256_core_if.slave bus
);
    import sha256_pkg::*;

    localparam int RPC = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_CNT = 6'(64 / RPC - 1);

    generate
        if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
            $error("sha256_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        UPDATE,
        DONE
    } state_t;

    typedef logic [31:0] word_t;

    state_t state;
    state_t state_nx;

    word_t h_st [8];
    word_t wv   [8];
    word_t w    [16];
    logic [5:0] cnt;
    logic last_q;
    logic mode_q;
    logic open_q;

    logic blk_ready_q;
    logic dig_valid_q;
    logic busy_q;
    logic [255:0] digest_q;

    logic accept;
    word_t init_w [8];
    word_t rnd_wv [8];
    word_t rnd_w  [16];
    word_t new_h  [8];
    logic [255:0] digest_nx;

    assign accept = bus.blk_valid & blk_ready_q;

    assign bus.blk_ready = blk_ready_q;
    assign bus.dig_valid = dig_valid_q;
    assign bus.busy      = busy_q;
    assign bus.digest    = digest_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ROUND;
            ROUND:   if (cnt == LAST_CNT) state_nx = UPDATE;
            UPDATE:  state_nx = last_q ? DONE : IDLE;
            DONE:    if (bus.dig_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Chaining state for a new block: IV when a fresh message starts
    // (explicitly or because none is open), otherwise the running H.
    always_comb begin
        logic fresh;
        logic [255:0] iv;
        fresh = bus.blk_first | ~open_q;
        iv = (bus.blk_first ? bus.mode : mode_q) ? IV224 : IV256;
        for (int i = 0; i < 8; i++) begin
            init_w[i] = fresh ? iv[255 - 32 * i -: 32] : h_st[i];
        end
    end

    // RPC rounds chained combinationally; w[0] is always W[t] for the
    // current round and the window slides by one word per round.
    always_comb begin
        word_t t1;
        word_t t2;
        word_t nw;
        logic [5:0] kidx;
        t1 = '0;
        t2 = '0;
        nw = '0;
        kidx = '0;
        rnd_wv = wv;
        rnd_w  = w;
        for (int i = 0; i < RPC; i++) begin
            kidx = 6'(int'(cnt) * RPC + i);
            t1 = rnd_wv[7] + sum1(rnd_wv[4])
               + ch(rnd_wv[4], rnd_wv[5], rnd_wv[6])
               + K[kidx] + rnd_w[0];
            t2 = sum0(rnd_wv[0]) + maj(rnd_wv[0], rnd_wv[1], rnd_wv[2]);
            nw = sig1(rnd_w[14]) + rnd_w[9] + sig0(rnd_w[1]) + rnd_w[0];
            for (int j = 7; j > 0; j--) begin
                rnd_wv[j] = rnd_wv[j - 1];
            end
            rnd_wv[4] = rnd_wv[4] + t1;
            rnd_wv[0] = t1 + t2;
            for (int j = 0; j < 15; j++) begin
                rnd_w[j] = rnd_w[j + 1];
            end
            rnd_w[15] = nw;
        end
    end

    always_comb begin
        digest_nx = '0;
        for (int i = 0; i < 8; i++) begin
            new_h[i] = h_st[i] + wv[i];
            digest_nx[255 - 32 * i -: 32] = new_h[i];
        end
        if (mode_q) begin
            digest_nx[31:0] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_st        <= '{default: '0};
            wv          <= '{default: '0};
            w           <= '{default: '0};
            cnt         <= '0;
            last_q      <= 1'b0;
            mode_q      <= 1'b0;
            open_q      <= 1'b0;
            blk_ready_q <= 1'b1;
            dig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            digest_q    <= '0;
        end else begin
            blk_ready_q <= (state_nx == IDLE);
            dig_valid_q <= (state_nx == DONE);
            busy_q      <= (state_nx == ROUND) || (state_nx == UPDATE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        h_st   <= init_w;
                        wv     <= init_w;
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= bus.blk_data[511 - 32 * i -: 32];
                        end
                        cnt    <= '0;
                        last_q <= bus.blk_last;
                        open_q <= 1'b1;
                        if (bus.blk_first) begin
                            mode_q <= bus.mode;
                        end
                    end
                end
                ROUND: begin
                    wv  <= rnd_wv;
                    w   <= rnd_w;
                    cnt <= cnt + 6'd1;
                end
                UPDATE: begin
                    h_st <= new_h;
                    if (last_q) begin
                        digest_q <= digest_nx;
                    end
                end
                DONE: begin
                    if (bus.dig_ready) begin
                        open_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_core.sv
// Testbench for sha256_core: four instances (1, 2, 4, 8 rounds/cycle) driven in lockstep.
// Checks known digests, latency, hold/backpressure, reset and a textbook reference model.
module tb_sha256_core;
    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         mode;
    logic         dig_ready;

    logic [3:0]   rdy;
    logic [3:0]   dv;
    logic [3:0]   bz;
    logic [255:0] dg [4];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    sha256_core_if bi[4] ();

    for (genvar k = 0; k < 4; k++) begin : g_dut
        sha256_core #(.ROUNDS_PER_CYCLE(1 << k)) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bi[k])
        );
        assign bi[k].blk_valid = blk_valid;
        assign bi[k].blk_data  = blk_data;
        assign bi[k].blk_first = blk_first;
        assign bi[k].blk_last  = blk_last;
        assign bi[k].mode      = mode;
        assign bi[k].dig_ready = dig_ready;
        assign rdy[k] = bi[k].blk_ready;
        assign dv[k]  = bi[k].dig_valid;
        assign bz[k]  = bi[k].busy;
        assign dg[k]  = bi[k].digest;
    end

    localparam logic [31:0] RK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_M1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] B_M2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] D_TWO =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_iv(input bit m);
        if (m)
            return {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
        return {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    endfunction

    // Textbook compression: full 64-word schedule expanded up front.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin,
                                                  input logic [511:0] blk);
        logic [31:0] ww [64];
        logic [31:0] hv [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) ww[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(ww[t-15], 7) ^ rr(ww[t-15], 18) ^ (ww[t-15] >> 3);
            s1 = rr(ww[t-2], 17) ^ rr(ww[t-2], 19) ^ (ww[t-2] >> 10);
            ww[t] = s1 + ww[t-7] + s0 + ww[t-16];
        end
        for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32 * i -: 32];
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g))
               + RK[t] + ww[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        res = {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
               hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
        return res;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " blk_ready"}, 256'(rdy), 256'hf);
        chk({tag, " dig_valid"}, 256'(dv), 256'h0);
        chk({tag, " busy"}, 256'(bz), 256'h0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s digest R%0d", tag, 1 << k), dg[k], 256'h0);
    endtask

    task automatic send_block(input string tag, input logic [511:0] d,
                              input bit f, input bit l, input bit m);
        int lat [4];
        bit all;
        @(negedge clk);
        chk({tag, " ready before"}, 256'(rdy), 256'hf);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        mode      = m;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        chk({tag, " busy after accept"}, 256'(bz), 256'hf);
        lat = '{default: -1};
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            all = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (lat[k] < 0 && (l ? dv[k] : rdy[k])) lat[k] = c;
                if (lat[k] < 0) all = 1'b0;
            end
            if (all) break;
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s latency R%0d", tag, 1 << k),
                256'(lat[k]), 256'(64 / (1 << k) + 1));
    endtask

    task automatic recv(input string tag, input logic [255:0] exp, input int hold);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s digest R%0d", tag, 1 << k), dg[k], exp);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, 256'(dv), 256'hf);
            chk({tag, " hold ready"}, 256'(rdy), 256'h0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s hold digest R%0d", tag, 1 << k), dg[k], exp);
        end
        @(negedge clk);
        dig_ready = 1'b1;
        @(posedge clk);
        #1;
        dig_ready = 1'b0;
        chk({tag, " ready after take"}, 256'(rdy), 256'hf);
        chk({tag, " valid after take"}, 256'(dv), 256'h0);
        chk({tag, " busy after take"}, 256'(bz), 256'h0);
    endtask

    initial begin
        rst = 1'b1;
        blk_valid = 1'b0;
        blk_data = '0;
        blk_first = 1'b0;
        blk_last = 1'b0;
        mode = 1'b0;
        dig_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("reset");

        send_block("abc256", B_ABC, 1'b1, 1'b1, 1'b0);
        recv("abc256", D_ABC, 0);

        send_block("abc224", B_ABC, 1'b1, 1'b1, 1'b1);
        recv("abc224", D_ABC224, 0);

        // mode on a continuation block must be ignored
        send_block("two b1", B_M1, 1'b1, 1'b0, 1'b0);
        send_block("two b2", B_M2, 1'b0, 1'b1, 1'b1);
        recv("two", D_TWO, 0);

        send_block("empty", B_EMPTY, 1'b1, 1'b1, 1'b0);
        recv("empty", D_EMPTY, 10);

        @(negedge clk);
        blk_valid = 1'b1;
        blk_data  = B_M1;
        blk_first = 1'b1;
        blk_last  = 1'b0;
        mode      = 1'b0;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midround busy", 256'(bz), 256'hf);
        chk("midround ready", 256'(rdy), 256'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("rst after");
        send_block("abc nofirst", B_ABC, 1'b0, 1'b1, 1'b0);
        recv("abc nofirst", D_ABC, 0);

        send_block("stale b1", B_M1, 1'b1, 1'b0, 1'b0);
        send_block("restart", B_ABC, 1'b1, 1'b1, 1'b0);
        recv("restart", D_ABC, 0);

        for (int m = 0; m < 5; m++) begin
            int nb;
            bit md;
            logic [255:0] h;
            logic [511:0] blk;
            nb = int'($urandom_range(1, 3));
            md = 1'($urandom_range(0, 1));
            h = ref_iv(md);
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < 16; j++) blk[511 - 32 * j -: 32] = $urandom();
                h = ref_compress(h, blk);
                send_block($sformatf("rand%0d b%0d", m, b), blk, b == 0, b == nb - 1,
                           (b == 0) ? md : 1'($urandom_range(0, 1)));
            end
            if (md) h[31:0] = '0;
            recv($sformatf("rand%0d", m), h, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
